// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit_if : instruction-memory and CPU-side bundle of the fetch unit
// Revision 1.0
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instruction, instr_pc, instr_pc_plus4, instr_valid,
    input  instr_ready, redirect, redirect_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instruction, instr_pc, instr_pc_plus4, instr_valid,
    output instr_ready, redirect, redirect_pc,
    input  fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit : PC owner, req/ack instruction fetch, prefetch FIFO, redirect
// Optional misaligned-redirect fault: define IFU_ALIGN_CHECK_EN. Revision 1.0
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]       r_state;
  logic             r_req;
  logic [31:0]      r_addr;
  logic [31:0]      r_fetch_pc;
  logic             r_fault;

  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_hold_data;
  logic [31:0]      r_hold_pc;

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_space_idle;
  logic             w_space_after;
  logic             w_misaligned;
  logic [31:0]      w_target;

`ifdef IFU_ALIGN_CHECK_EN
  assign w_misaligned = |bus.redirect_pc[1:0];
`else
  logic w_unused_lo;
  assign w_misaligned = 1'b0;
  assign w_unused_lo  = |bus.redirect_pc[1:0];
`endif

  assign w_target      = {bus.redirect_pc[31:2], 2'b00};
  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && bus.instr_ready;
  assign w_push        = (r_state == S_REQ) && bus.imem_ack && !bus.redirect;
  // A same-cycle pop frees a slot, so it counts toward the space checks.
  assign w_space_idle  = (r_count < c_DEPTH) || w_pop;
  assign w_space_after = w_pop ? (r_count < c_DEPTH) : (r_count < c_DEPTH_M1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_fault    <= 1'b0;
    end else if (bus.redirect) begin
      r_fetch_pc <= w_target;
      r_fault    <= w_misaligned;
      // An outstanding request cannot be withdrawn; drain it in DROP.
      if ((r_state != S_IDLE) && !bus.imem_ack) begin
        r_state <= S_DROP;
      end else begin
        r_state <= S_IDLE;
        r_req   <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_fault && w_space_idle) begin
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.imem_ack) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_space_after) begin
              r_addr <= r_fetch_pc + 32'd4;
            end else begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (bus.imem_ack) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_hold_data <= 32'h0;
      r_hold_pc   <= 32'h0;
    end else begin
      if (w_valid) begin
        r_hold_data <= r_fifo_data[r_rd_ptr];
        r_hold_pc   <= r_fifo_pc[r_rd_ptr];
      end
      if (bus.redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  assign bus.imem_req       = r_req;
  assign bus.imem_addr      = r_addr;
  assign bus.instr_valid    = w_valid;
  assign bus.instruction    = w_valid ? r_fifo_data[r_rd_ptr] : r_hold_data;
  assign bus.instr_pc       = w_valid ? r_fifo_pc[r_rd_ptr] : r_hold_pc;
  assign bus.instr_pc_plus4 = bus.instr_pc + 32'd4;
  assign bus.fetch_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);                       // request to 0 now outstanding
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: req=%b addr=%h valid=%b want 0/0/0", bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    n_checks++;
    if (bus.instruction !== 32'h0 || bus.instr_pc !== 32'h0 || bus.instr_pc_plus4 !== 32'h4 || bus.fetch_fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: instr=%h pc=%h pc4=%h fault=%b want 0/0/4/0", bus.instruction, bus.instr_pc, bus.instr_pc_plus4, bus.fetch_fault);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    apply_reset();
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL b2b_addr[%0d]: req=%b addr=%h want 1/%h", k, bus.imem_req, bus.imem_addr, 32'(4 * k));
      end
      n_checks++;
      if (k == 0) begin
        if (bus.instr_valid !== 1'b0) begin
          n_fail++; $display("FAIL b2b_first_valid: got %b want 0", bus.instr_valid);
        end
      end else begin
        exp_pc = 32'(4 * (k - 1));
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc || bus.instruction !== mem_word(exp_pc) || bus.instr_pc_plus4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL b2b_out[%0d]: valid=%b pc=%h instr=%h pc4=%h want 1/%h/%h/%h", k, bus.instr_valid, bus.instr_pc, bus.instruction, bus.instr_pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
      end
    end
  endtask

  task automatic test_ack_delay();
    apply_reset();
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL wait_hold[%0d]: req=%b addr=%h valid=%b want 1/0/0", k, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
    end
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instruction !== mem_word(32'h0) || bus.imem_addr !== 32'h4) begin
      n_fail++; $display("FAIL ack_push: valid=%b pc=%h instr=%h addr=%h want 1/0/%h/4", bus.instr_valid, bus.instr_pc, bus.instruction, bus.imem_addr, mem_word(32'h0));
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL single_entry: valid=%b pc=%h want 0/0", bus.instr_valid, bus.instr_pc);
    end
  endtask

  task automatic test_fifo_full();
    int nreq;
    nreq = 0;
    apply_reset();
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) nreq++;
    end
    n_checks++;
    if (nreq !== DEPTH || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL full_reqs: issued=%0d req=%b want %0d/0", nreq, bus.imem_req, DEPTH);
    end
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL full_head: valid=%b pc=%h want 1/0", bus.instr_valid, bus.instr_pc);
    end
    bus.instr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * DEPTH)) begin
          n_fail++; $display("FAIL resume_addr: req=%b addr=%h want 1/%h", bus.imem_req, bus.imem_addr, 32'(4 * DEPTH));
        end
      end
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * k) || bus.instruction !== mem_word(32'(4 * k))) begin
        n_fail++; $display("FAIL resume_seq[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h", k, bus.instr_valid, bus.instr_pc, bus.instruction, 32'(4 * k), mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_redirect_drop();
    apply_reset();
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.imem_addr !== 32'h8 || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL drop_setup: req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_hold: req=%b addr=%h valid=%b want 1/8/0", bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    @(negedge clk);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_discard: req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid);
    end
    @(negedge clk);
    bus.imem_ack = 1'b1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL drop_newreq: req=%b addr=%h want 1/100", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instruction !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL drop_first: valid=%b pc=%h instr=%h want 1/100/%h", bus.instr_valid, bus.instr_pc, bus.instruction, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_ack_wrap();
    apply_reset();
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_ack: req=%b valid=%b want 0/0", bus.imem_req, bus.instr_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC || bus.instr_pc_plus4 !== 32'h0 || bus.imem_addr !== 32'h0 || bus.instruction !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_out: valid=%b pc=%h pc4=%h addr=%h instr=%h want 1/fffffffc/0/0/%h", bus.instr_valid, bus.instr_pc, bus.instr_pc_plus4, bus.imem_addr, bus.instruction, mem_word(32'hFFFF_FFFC));
    end
    @(negedge clk);
    n_checks++;
    if (bus.instr_pc !== 32'h0 || bus.instr_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL wrap_next: pc=%h pc4=%h want 0/4", bus.instr_pc, bus.instr_pc_plus4);
    end
  endtask

  task automatic test_align();
    apply_reset();
    bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0102;
    @(negedge clk);
    bus.redirect = 1'b0; bus.imem_ack = 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
    n_checks++;
    if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL fault_set: fault=%b req=%b addr=%h want 1/1/0", bus.fetch_fault, bus.imem_req, bus.imem_addr);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL fault_stall: fault=%b req=%b valid=%b want 1/0/0", bus.fetch_fault, bus.imem_req, bus.instr_valid);
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++;
    if (bus.fetch_fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_clear: fault=%b want 0", bus.fetch_fault);
    end
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL fault_resume: req=%b addr=%h want 1/200", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200) begin
      n_fail++; $display("FAIL fault_first: valid=%b pc=%h want 1/200", bus.instr_valid, bus.instr_pc);
    end
`else
    n_checks++;
    if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL nofault_drop: fault=%b req=%b addr=%h want 0/1/0", bus.fetch_fault, bus.imem_req, bus.imem_addr);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.fetch_fault !== 1'b0) begin
      n_fail++; $display("FAIL nofault_mask: req=%b addr=%h fault=%b want 1/100/0", bus.imem_req, bus.imem_addr, bus.fetch_fault);
    end
    @(negedge clk);
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100) begin
      n_fail++; $display("FAIL nofault_first: valid=%b pc=%h want 1/100", bus.instr_valid, bus.instr_pc);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_ack_delay();
    test_fifo_full();
    test_redirect_drop();
    test_redirect_ack_wrap();
    test_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-supply side of the single-cycle CPU's `instruction` input.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Memory latency is variable.
- Buffers fetched words in a small prefetch FIFO and presents them to the CPU with valid/ready.
- The CPU sends branch/jump/jr/jal targets back on a redirect port; a redirect flushes in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; legal values are 2 or 4.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word address of the request; bits [1:0] are always 0.
- imem_ack  input  1  memory completes the request this cycle; imem_rdata is valid.
- imem_rdata  input  32  instruction word returned.
- instruction  output  32  instruction word presented to the CPU.
- instr_pc  output  32  address of `instruction`.
- instr_pc_plus4  output  32  instr_pc + 4, for the CPU's jal/ra path.
- instr_valid  output  1  instruction/instr_pc are valid.
- instr_ready  input  1  CPU consumes the head entry this cycle.
- redirect  input  1  CPU-resolved control transfer.
- redirect_pc  input  32  new fetch target.
- fetch_fault  output  1  misaligned redirect flag; exists only with the optional feature.

Behaviour:
- Reset (reset_n=0 at an edge):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, instr_pc_plus4=4, fetch_fault=0.
  - FIFO is emptied, state=IDLE, fetch_pc=RESET_PC.
  - Reset asserted mid-transaction abandons it; any later ack is ignored until the next request is issued.
- States: IDLE, REQ, DROP.
  - IDLE: if (fifo_count + 0) < FIFO_DEPTH, assert imem_req with imem_addr=fetch_pc and go to REQ. Request is registered, so it appears the cycle after the decision.
  - REQ: imem_req and imem_addr are held stable until imem_ack.
    - On ack: push {fetch_pc, imem_rdata}, fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
    - Then go to REQ again if space remains after the push, else IDLE.
  - DROP: entered on a redirect while a request is outstanding.
    - Keep imem_req high with the old address; handshake rules forbid withdrawing a request.
    - Discard data on ack and go to IDLE.
- Back-to-back: with ack tied high, one word per cycle is sustained while the CPU consumes every cycle.
- Latency: ack at edge N gives instr_valid=1 after edge N, provided the FIFO was empty.
- CPU side:
  - Head entry drives instruction/instr_pc/instr_pc_plus4.
  - Pop occurs when instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full, given the space check counts the pop.
  - Output values are undefined-but-stable while instr_valid=0; they hold their last value.
- Redirect (highest priority):
  - The FIFO is flushed and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - A pop in the same cycle is still a legal consumption.
  - Redirect with an ack in the same cycle: data is discarded, the transaction is complete, and the next state is IDLE.
  - Redirect while in REQ without an ack: go to DROP.
  - Redirect while in DROP: update fetch_pc and remain in DROP.
  - instr_valid=0 in the cycle after any redirect.
- Full: no new request while count == FIFO_DEPTH and no pop. Empty: instr_valid=0.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined:
  - Redirect with redirect_pc[1:0] != 0 sets fetch_fault=1 (sticky) and flushes the FIFO.
  - No further requests are issued; an outstanding request is drained via DROP.
  - Cleared by reset or by an aligned redirect, which resumes fetch at that target.
- Undefined:
  - fetch_fault port is tied 0.
  - Low bits of redirect_pc are silently forced to 0.

Test Plan:
- Reset release, ack tied 1, instr_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; instr_pc follows 1 cycle behind; instruction equals memory content.
- Ack delayed 3 cycles -> imem_req/imem_addr stay stable across the wait; exactly one entry is pushed; instr_valid rises the cycle after ack.
- instr_ready=0 for 6 cycles -> exactly FIFO_DEPTH requests issued, then imem_req=0; raising ready resumes at PC 4*FIFO_DEPTH with no skip or duplicate.
- Redirect to 32'h0000_0100 while a request to 0x8 is outstanding, ack 2 cycles later -> 0x8 data dropped; next request addr 0x100; first valid instr_pc=0x100.
- Redirect and ack in the same cycle; also fetch at 32'hFFFF_FFFC -> acked data discarded and next req at the target; wrap: next addr 0x0, instr_pc_plus4=0.
- IFU_ALIGN_CHECK_EN: redirect_pc=32'h0000_0102 -> fetch_fault=1, no new imem_req; then redirect 0x200 -> fault clears and fetch resumes at 0x200.
